// File: rtl/fusa_mon_pkg.sv
// Shared types and helpers for the FuSa error monitor.
// Shared by the monitor top and its per-memory error channels.
package fusa_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WARN  = 2'd1,
      ST_ALARM = 2'd2
   } fusa_state_e;

   localparam logic SRC_MEM1 = 1'b0;
   localparam logic SRC_MEM2 = 1'b1;

   // Next counter value. Clear wins first, then an event on a decay edge nets to zero change.
   function automatic int unsigned cnt_next(input int unsigned cnt,
                                            input logic        evt,
                                            input logic        dec,
                                            input logic        clr,
                                            input int unsigned cnt_max);
      if (clr)
         cnt_next = evt ? 32'd1 : 32'd0;
      else if (evt && dec && cnt != 0)
         cnt_next = cnt;
      else if (evt)
         cnt_next = (cnt == cnt_max) ? cnt : cnt + 32'd1;
      else if (dec && cnt != 0)
         cnt_next = cnt - 32'd1;
      else
         cnt_next = cnt;
   endfunction

endpackage

// File: rtl/fusa_err_chan.sv
// One memory's error channel: rising-edge event detect plus saturating up/down event counter.
module fusa_err_chan
   import fusa_mon_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det,
   input  logic             corr,
   input  logic             clr,
   input  logic             dec,
   output logic             evt,
   output logic             severe,
   output logic [CNT_W-1:0] cnt
);

   localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

   logic det_q;

   assign evt    = det & ~det_q;
   assign severe = evt & ~corr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         det_q <= 1'b0;
         cnt   <= '0;
      end else begin
         det_q <= det;
         cnt   <= CNT_W'(cnt_next(32'(cnt), evt, dec, clr, CNT_MAX));
      end
   end

endmodule

// File: rtl/fusa_err_monitor.sv
// FuSa error monitor: per-memory event counting, first-error capture, IDLE/WARN/ALARM escalation.
// Define FUSA_LEAK_EN to enable periodic counter decay and WARN->IDLE recovery.
module fusa_err_monitor
   import fusa_mon_pkg::*;
#(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned CNT_W        = 4,
   parameter int unsigned ALARM_THRESH = 4,
   parameter int unsigned DECAY_PERIOD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem1_err_detected,
   input  logic              mem1_err_corrected,
   input  logic [ADDR_W-1:0] mem1_addr,
   input  logic              mem2_err_detected,
   input  logic              mem2_err_corrected,
   input  logic [ADDR_W-1:0] mem2_addr,
   input  logic              clr_req,
   output logic              clr_ack,
   output logic [CNT_W-1:0]  mem1_err_cnt,
   output logic [CNT_W-1:0]  mem2_err_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              first_err_src,
   output logic              first_err_vld,
   output logic              warn,
   output logic              alarm
);

   localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

   if (ALARM_THRESH < 1 || ALARM_THRESH > CNT_MAX || DECAY_PERIOD < 1) begin : g_cfg_err
      $error("fusa_err_monitor: invalid parameter set");
   end

   fusa_state_e state;
   logic        evt1, sev1, evt2, sev2;
   logic        dec, clr_rise;
   logic        any_evt, alarm_hit, decay_idle, vld_eff;
   int unsigned n1, n2;

   assign clr_rise = clr_req & ~clr_ack;

`ifdef FUSA_LEAK_EN
   localparam int unsigned PER_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   logic [PER_W-1:0] period;
   logic             wrap;

   assign wrap = (32'(period) == DECAY_PERIOD - 1);
   assign dec  = wrap & ~clr_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         period <= '0;
      else if (clr_rise || wrap)
         period <= '0;
      else
         period <= period + PER_W'(1);
   end
`else
   assign dec = 1'b0;
`endif

   fusa_err_chan #(.CNT_W(CNT_W)) u_chan1 (
      .clk    (clk),
      .rst    (rst),
      .det    (mem1_err_detected),
      .corr   (mem1_err_corrected),
      .clr    (clr_rise),
      .dec    (dec),
      .evt    (evt1),
      .severe (sev1),
      .cnt    (mem1_err_cnt)
   );

   fusa_err_chan #(.CNT_W(CNT_W)) u_chan2 (
      .clk    (clk),
      .rst    (rst),
      .det    (mem2_err_detected),
      .corr   (mem2_err_corrected),
      .clr    (clr_rise),
      .dec    (dec),
      .evt    (evt2),
      .severe (sev2),
      .cnt    (mem2_err_cnt)
   );

   // Post-edge counts let the threshold fire on the same edge as the increment.
   assign n1 = cnt_next(32'(mem1_err_cnt), evt1, dec, clr_rise, CNT_MAX);
   assign n2 = cnt_next(32'(mem2_err_cnt), evt2, dec, clr_rise, CNT_MAX);

   assign any_evt    = evt1 | evt2;
   assign alarm_hit  = sev1 || sev2 || (evt1 && n1 >= ALARM_THRESH) || (evt2 && n2 >= ALARM_THRESH);
   assign decay_idle = dec && (n1 == 0) && (n2 == 0) && (state == ST_WARN);
   assign vld_eff    = first_err_vld & ~clr_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         warn           <= 1'b0;
         alarm          <= 1'b0;
         clr_ack        <= 1'b0;
         first_err_addr <= '0;
         first_err_src  <= SRC_MEM1;
         first_err_vld  <= 1'b0;
      end else begin
         clr_ack <= clr_req;

         // A clear on this edge drops to IDLE before the same-edge events are re-evaluated.
         if (alarm_hit) begin
            state <= ST_ALARM;
            warn  <= 1'b0;
            alarm <= 1'b1;
         end else if (state == ST_ALARM && !clr_rise) begin
            state <= ST_ALARM;
         end else if (any_evt) begin
            state <= ST_WARN;
            warn  <= 1'b1;
            alarm <= 1'b0;
         end else if (clr_rise || decay_idle) begin
            state <= ST_IDLE;
            warn  <= 1'b0;
            alarm <= 1'b0;
         end

         if (!vld_eff && any_evt) begin
            first_err_addr <= evt1 ? mem1_addr : mem2_addr;
            first_err_src  <= evt1 ? SRC_MEM1 : SRC_MEM2;
            first_err_vld  <= 1'b1;
         end else if (clr_rise) begin
            first_err_addr <= '0;
            first_err_src  <= SRC_MEM1;
            first_err_vld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fusa_err_monitor.sv
// Directed + random bench for fusa_err_monitor against a behavioural reference model.
module tb_fusa_err_monitor;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned THRESH = 4;
   localparam int unsigned DECAY  = 16;
   localparam int unsigned MAXC   = 15;
   localparam int M_IDLE = 0, M_WARN = 1, M_ALARM = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mem1_err_detected = 1'b0, mem1_err_corrected = 1'b0;
   logic [ADDR_W-1:0] mem1_addr = '0;
   logic              mem2_err_detected = 1'b0, mem2_err_corrected = 1'b0;
   logic [ADDR_W-1:0] mem2_addr = '0;
   logic              clr_req = 1'b0;
   logic              clr_ack;
   logic [CNT_W-1:0]  mem1_err_cnt, mem2_err_cnt;
   logic [ADDR_W-1:0] first_err_addr;
   logic              first_err_src, first_err_vld, warn, alarm;

   int errors = 0;
   int checks = 0;

   int unsigned m_cnt1, m_cnt2, m_addr, m_src, m_vld, m_ack, m_prev1, m_prev2, m_per;
   int          m_state;

   always #5 clk = ~clk;

   fusa_err_monitor #(
      .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ALARM_THRESH(THRESH), .DECAY_PERIOD(DECAY)
   ) dut (
      .clk(clk), .rst(rst),
      .mem1_err_detected(mem1_err_detected), .mem1_err_corrected(mem1_err_corrected), .mem1_addr(mem1_addr),
      .mem2_err_detected(mem2_err_detected), .mem2_err_corrected(mem2_err_corrected), .mem2_addr(mem2_addr),
      .clr_req(clr_req), .clr_ack(clr_ack),
      .mem1_err_cnt(mem1_err_cnt), .mem2_err_cnt(mem2_err_cnt),
      .first_err_addr(first_err_addr), .first_err_src(first_err_src), .first_err_vld(first_err_vld),
      .warn(warn), .alarm(alarm)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".cnt1"}, 32'(mem1_err_cnt), m_cnt1);
      chk({tag, ".cnt2"}, 32'(mem2_err_cnt), m_cnt2);
      chk({tag, ".addr"}, 32'(first_err_addr), m_addr);
      chk({tag, ".src"},  32'(first_err_src), m_src);
      chk({tag, ".vld"},  32'(first_err_vld), m_vld);
      chk({tag, ".ack"},  32'(clr_ack), m_ack);
      chk({tag, ".warn"}, 32'(warn), (m_state == M_WARN) ? 32'd1 : 32'd0);
      chk({tag, ".alarm"}, 32'(alarm), (m_state == M_ALARM) ? 32'd1 : 32'd0);
   endtask

   function automatic int unsigned bump(input int unsigned c, input int unsigned e, input bit d);
      if (d && c > 0) return c - 1 + e;
      return (c + e > MAXC) ? MAXC : c + e;
   endfunction

   task automatic model_reset();
      m_cnt1 = 0; m_cnt2 = 0; m_addr = 0; m_src = 0; m_vld = 0;
      m_ack = 0; m_prev1 = 0; m_prev2 = 0; m_per = 0; m_state = M_IDLE;
   endtask

   // Advance the model by the inputs currently applied, then clock the DUT and compare.
   task automatic tick(input string tag);
      int unsigned e1, e2;
      bit          s, rise, d;
      e1   = (mem1_err_detected && m_prev1 == 0) ? 1 : 0;
      e2   = (mem2_err_detected && m_prev2 == 0) ? 1 : 0;
      s    = (e1 != 0 && !mem1_err_corrected) || (e2 != 0 && !mem2_err_corrected);
      rise = clr_req && m_ack == 0;
      d    = 1'b0;
`ifdef FUSA_LEAK_EN
      d     = (m_per == DECAY - 1) && !rise;
      m_per = (rise || m_per == DECAY - 1) ? 0 : m_per + 1;
`endif
      if (rise) begin
         m_cnt1 = 0; m_cnt2 = 0; m_addr = 0; m_src = 0; m_vld = 0; m_state = M_IDLE;
      end
      m_cnt1 = bump(m_cnt1, e1, d);
      m_cnt2 = bump(m_cnt2, e2, d);
      if (m_vld == 0 && (e1 + e2) > 0) begin
         m_vld  = 1;
         m_src  = (e1 != 0) ? 0 : 1;
         m_addr = (e1 != 0) ? 32'(mem1_addr) : 32'(mem2_addr);
      end
      if (m_state != M_ALARM) begin
         if (s || (e1 != 0 && m_cnt1 >= THRESH) || (e2 != 0 && m_cnt2 >= THRESH)) m_state = M_ALARM;
         else if ((e1 + e2) > 0) m_state = M_WARN;
         else if (d && m_cnt1 == 0 && m_cnt2 == 0) m_state = M_IDLE;
      end
      m_ack   = clr_req ? 1 : 0;
      m_prev1 = mem1_err_detected ? 1 : 0;
      m_prev2 = mem2_err_detected ? 1 : 0;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
   task automatic do_reset();
      #2;
      mem1_err_detected = 0; mem1_err_corrected = 0; mem1_addr = '0;
      mem2_err_detected = 0; mem2_err_corrected = 0; mem2_addr = '0;
      clr_req = 0;
      rst = 1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   task automatic pulse1(input logic [ADDR_W-1:0] a, input logic c);
      mem1_err_detected = 1; mem1_err_corrected = c; mem1_addr = a;
      tick("p1_hi");
      mem1_err_detected = 0;
      tick("p1_lo");
   endtask

   task automatic pulse2(input logic [ADDR_W-1:0] a, input logic c);
      mem2_err_detected = 1; mem2_err_corrected = c; mem2_addr = a;
      tick("p2_hi");
      mem2_err_detected = 0;
      tick("p2_lo");
   endtask

   initial begin
      model_reset();
      // 1: reset and idle
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 20; i++) tick("t1_idle");

      // 2: three corrected MEM1 pulses, then a fourth crosses the threshold
      pulse1(8'h05, 1'b1);
      pulse1(8'h06, 1'b1);
      pulse1(8'h07, 1'b1);
      chk("t2_cnt3", 32'(mem1_err_cnt), 32'd3);
      chk("t2_warn", 32'(warn), 32'd1);
      chk("t2_addr", 32'(first_err_addr), 32'h05);
      chk("t2_src", 32'(first_err_src), 32'd0);
      mem1_err_detected = 1; mem1_err_corrected = 1; mem1_addr = 8'h08;
      tick("t2_p4");
      chk("t2_alarm", 32'(alarm), 32'd1);
      mem1_err_detected = 0;
      tick("t2_p4_lo");

      // 1 (cont.): async reset while in ALARM
      do_reset();
      chk("t1_alarm_cleared", 32'(alarm), 32'd0);

      // 3: held level counts once; MEM2 saturates
      mem1_err_detected = 1; mem1_err_corrected = 1; mem1_addr = 8'h33;
      for (int i = 0; i < 10; i++) tick("t3_hold");
      mem1_err_detected = 0;
      tick("t3_hold_lo");
      chk("t3_cnt1", 32'(mem1_err_cnt), 32'd1);
      for (int i = 0; i < 20; i++) pulse2(8'($urandom), 1'b1);
      chk("t3_sat", 32'(mem2_err_cnt), 32'd15);
      chk("t3_alarm", 32'(alarm), 32'd1);

      // 4: same-edge first events, MEM1 wins the capture
      do_reset();
      mem1_err_detected = 1; mem1_err_corrected = 1; mem1_addr = 8'h10;
      mem2_err_detected = 1; mem2_err_corrected = 1; mem2_addr = 8'h20;
      tick("t4_tie");
      chk("t4_addr", 32'(first_err_addr), 32'h10);
      chk("t4_src", 32'(first_err_src), 32'd0);
      chk("t4_cnt2", 32'(mem2_err_cnt), 32'd1);
      mem1_err_detected = 0; mem2_err_detected = 0;
      tick("t4_lo");

      // 5: single severe MEM2 event from IDLE
      do_reset();
      mem2_err_detected = 1; mem2_err_corrected = 0; mem2_addr = 8'h44;
      tick("t5_sev");
      chk("t5_alarm", 32'(alarm), 32'd1);
      chk("t5_cnt2", 32'(mem2_err_cnt), 32'd1);
      mem2_err_detected = 0;
      tick("t5_lo");

      // 6: clear handshake from ALARM with a MEM1 event on the ack-rise edge
      clr_req = 1;
      mem1_err_detected = 1; mem1_err_corrected = 1; mem1_addr = 8'h55;
      tick("t6_rise");
      chk("t6_ack", 32'(clr_ack), 32'd1);
      chk("t6_cnt1", 32'(mem1_err_cnt), 32'd1);
      chk("t6_cnt2", 32'(mem2_err_cnt), 32'd0);
      chk("t6_warn", 32'(warn), 32'd1);
      mem1_err_detected = 0;
      tick("t6_hold");
      clr_req = 0;
      tick("t6_fall");
      chk("t6_ack_fall", 32'(clr_ack), 32'd0);

`ifdef FUSA_LEAK_EN
      // 7: one corrected event decays away
      do_reset();
      pulse1(8'h66, 1'b1);
      for (int i = 0; i < 16; i++) tick("t7_decay");
      chk("t7_cnt", 32'(mem1_err_cnt), 32'd0);
      chk("t7_warn", 32'(warn), 32'd0);
`endif

      // Random traffic with occasional clear handshakes
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) mem1_err_detected = ~mem1_err_detected;
         if ($urandom_range(0, 2) == 0) mem2_err_detected = ~mem2_err_detected;
         mem1_err_corrected = ($urandom_range(0, 9) != 0);
         mem2_err_corrected = ($urandom_range(0, 9) != 0);
         mem1_addr = 8'($urandom);
         mem2_addr = 8'($urandom);
         if ($urandom_range(0, 9) == 0) clr_req = ~clr_req;
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
